// File: rtl/vga_mem_wr_arbiter_if.sv
// +----------------------------------------------------------------------+
// | vga_mem_wr_arbiter_if : core/fill/RAM write-port bundle               |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

interface vga_mem_wr_arbiter_if #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32
);
  logic              core_req;
  logic [ADDR_W-1:0] core_addr;
  logic [DATA_W-1:0] core_data;
  logic              core_ack;
  logic              core_err;
  logic              clr_start;
  logic [DATA_W-1:0] clr_pattern;
  logic              clr_busy;
  logic              clr_done;
  logic [ADDR_W-1:0] mem_wraddress;
  logic [DATA_W-1:0] mem_data;
  logic              mem_wren;

  modport master (
    output core_req, core_addr, core_data, clr_start, clr_pattern,
    input  core_ack, core_err, clr_busy, clr_done,
    input  mem_wraddress, mem_data, mem_wren
  );

  modport slave (
    input  core_req, core_addr, core_data, clr_start, clr_pattern,
    output core_ack, core_err, clr_busy, clr_done,
    output mem_wraddress, mem_data, mem_wren
  );
endinterface

`default_nettype wire

// File: rtl/vga_mem_wr_arbiter.sv
// +----------------------------------------------------------------------+
// | vga_mem_wr_arbiter : frame-RAM write port shared by core and filler   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module vga_mem_wr_arbiter #(
  // 14 bits are needed to reach word 9599
  parameter int ADDR_W    = 14,
  parameter int DATA_W    = 32,
  parameter int NUM_WORDS = 9600
) (
  input  logic                    clock,
  input  logic                    rst_n,
  vga_mem_wr_arbiter_if.slave     wr_if
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(NUM_WORDS - 1);
  localparam logic [ADDR_W:0]   NUM_WORDS_W = (ADDR_W + 1)'(NUM_WORDS);

  state_e            state_q,     state_d;
  logic [ADDR_W-1:0] cnt_q,       cnt_d;
  logic [DATA_W-1:0] pattern_q,   pattern_d;
  logic              last_fill_q, last_fill_d;
  logic [ADDR_W-1:0] wraddr_q,    wraddr_d;
  logic [DATA_W-1:0] wdata_q,     wdata_d;
  logic              wren_q,      wren_d;
  logic              err_q,       err_d;
  logic              done_q,      done_d;

  logic core_gnt;
  logic fill_gnt;
  logic core_in_range;
  logic fill_last;

  assign core_in_range = ({1'b0, wr_if.core_addr} < NUM_WORDS_W);
  assign fill_last     = (cnt_q == LAST_ADDR);

  // Under contention the winner is the opposite of whoever was granted last
  always_comb begin
    core_gnt = 1'b0;
    fill_gnt = 1'b0;
    if (state_q == ST_IDLE) begin
      core_gnt = wr_if.core_req;
    end else if (!wr_if.core_req) begin
      fill_gnt = 1'b1;
    end else if (last_fill_q) begin
      core_gnt = 1'b1;
    end else begin
      fill_gnt = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pattern_d   = pattern_q;
    last_fill_d = last_fill_q;
    wraddr_d    = wraddr_q;
    wdata_d     = wdata_q;
    wren_d      = 1'b0;
    err_d       = 1'b0;
    done_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (wr_if.clr_start) begin
          state_d   = ST_CLEAR;
          cnt_d     = '0;
          pattern_d = wr_if.clr_pattern;
        end
      end
      ST_CLEAR: begin
        if (fill_gnt && fill_last) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // An out-of-range core slot is consumed but never reaches the RAM
    if (core_gnt) begin
      last_fill_d = 1'b0;
      if (core_in_range) begin
        wren_d   = 1'b1;
        wraddr_d = wr_if.core_addr;
        wdata_d  = wr_if.core_data;
      end else begin
        err_d = 1'b1;
      end
    end

    if (fill_gnt) begin
      last_fill_d = 1'b1;
      wren_d      = 1'b1;
      wraddr_d    = cnt_q;
      wdata_d     = pattern_q;
      cnt_d       = cnt_q + 1'b1;
      done_d      = fill_last;
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      pattern_q   <= '0;
      last_fill_q <= 1'b1;
      wraddr_q    <= '0;
      wdata_q     <= '0;
      wren_q      <= 1'b0;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pattern_q   <= pattern_d;
      last_fill_q <= last_fill_d;
      wraddr_q    <= wraddr_d;
      wdata_q     <= wdata_d;
      wren_q      <= wren_d;
      err_q       <= err_d;
      done_q      <= done_d;
    end
  end

  assign wr_if.core_ack      = core_gnt;
  assign wr_if.core_err      = err_q;
  assign wr_if.clr_busy      = (state_q == ST_CLEAR) | done_q;
  assign wr_if.clr_done      = done_q;
  assign wr_if.mem_wraddress = wraddr_q;
  assign wr_if.mem_data      = wdata_q;
  assign wr_if.mem_wren      = wren_q;

endmodule

`default_nettype wire

// File: tb/tb_vga_mem_wr_arbiter.sv
// +----------------------------------------------------------------------+
// | tb_vga_mem_wr_arbiter : scoreboard bench for vga_mem_wr_arbiter       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_vga_mem_wr_arbiter;

  localparam int AW = 14;
  localparam int DW = 32;
  localparam int N  = 9600;

  typedef struct packed {
    logic          wren;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          err;
    logic          done;
    logic          busy;
  } exp_t;

  logic clock = 1'b0;
  logic rst_n = 1'b0;
  always #5 clock = ~clock;

  vga_mem_wr_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus_if ();

  vga_mem_wr_arbiter #(.ADDR_W(AW), .DATA_W(DW), .NUM_WORDS(N)) dut (
    .clock (clock),
    .rst_n (rst_n),
    .wr_if (bus_if)
  );

  exp_t          sbq[$];
  int            checks   = 0;
  int            failures = 0;
  int            done_cnt = 0;
  int            busy_cnt = 0;
  logic [DW-1:0] ram [N];

  // Reference model: frame-fill progress and who was served last
  bit            pend;
  bit            m_clear;
  bit            m_last_fill;
  int            m_cnt;
  logic [DW-1:0] m_pat;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  always @(posedge clock) begin
    exp_t me;
    #2;
    if (sbq.size() > 0) begin
      me = sbq.pop_front();
      chk("mem_wren", 64'(bus_if.mem_wren), 64'(me.wren));
      if (me.wren) begin
        chk("mem_wraddress", 64'(bus_if.mem_wraddress), 64'(me.addr));
        chk("mem_data", 64'(bus_if.mem_data), 64'(me.data));
      end
      chk("core_err", 64'(bus_if.core_err), 64'(me.err));
      chk("clr_done", 64'(bus_if.clr_done), 64'(me.done));
      chk("clr_busy", 64'(bus_if.clr_busy), 64'(me.busy));
    end
    if (bus_if.mem_wren && (int'(bus_if.mem_wraddress) < N))
      ram[bus_if.mem_wraddress] = bus_if.mem_data;
    if (bus_if.clr_done) done_cnt++;
    if (bus_if.clr_busy) busy_cnt++;
  end

  task automatic step(input int req_pct, input bit start, input logic [DW-1:0] pat);
    bit   cg;
    bit   fg;
    bit   was_clear;
    exp_t e;
    @(negedge clock);
    if (!pend && (int'($urandom_range(99)) < req_pct)) begin
      pend = 1'b1;
      if ($urandom_range(15) == 0)
        bus_if.core_addr = AW'($urandom_range(N, (2 ** AW) - 1));
      else
        bus_if.core_addr = AW'($urandom_range(N - 1));
      bus_if.core_data = $urandom();
    end
    bus_if.core_req    = pend;
    bus_if.clr_start   = start;
    bus_if.clr_pattern = pat;
    #1;
    was_clear = m_clear;
    cg = 1'b0;
    fg = 1'b0;
    if (m_clear && pend) begin
      if (m_last_fill) cg = 1'b1;
      else             fg = 1'b1;
    end else begin
      cg = pend && !m_clear;
      fg = m_clear;
    end
    chk("core_ack", 64'(bus_if.core_ack), 64'(cg));
    e = '0;
    if (cg) begin
      if (int'(bus_if.core_addr) < N) begin
        e.wren = 1'b1;
        e.addr = bus_if.core_addr;
        e.data = bus_if.core_data;
      end else begin
        e.err = 1'b1;
      end
      m_last_fill = 1'b0;
      pend        = 1'b0;
    end
    if (fg) begin
      e.wren      = 1'b1;
      e.addr      = AW'(m_cnt);
      e.data      = m_pat;
      e.done      = (m_cnt == N - 1);
      m_cnt       = m_cnt + 1;
      m_last_fill = 1'b1;
    end
    if (e.done) m_clear = 1'b0;
    if (!was_clear && start) begin
      m_clear = 1'b1;
      m_cnt   = 0;
      m_pat   = pat;
    end
    e.busy = m_clear | e.done;
    sbq.push_back(e);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && pend; i++) step(0, 1'b0, '0);
    step(0, 1'b0, '0);
    step(0, 1'b0, '0);
  endtask

  task automatic load_req(input logic [AW-1:0] a, input logic [DW-1:0] d);
    pend             = 1'b1;
    bus_if.core_addr = a;
    bus_if.core_data = d;
  endtask

  task automatic model_reset();
    pend        = 1'b0;
    m_clear     = 1'b0;
    m_last_fill = 1'b1;
    m_cnt       = 0;
    m_pat       = '0;
  endtask

  initial begin
    logic [DW-1:0] pat2;
    bus_if.core_req    = 1'b0;
    bus_if.core_addr   = '0;
    bus_if.core_data   = '0;
    bus_if.clr_start   = 1'b0;
    bus_if.clr_pattern = '0;
    model_reset();

    repeat (3) @(posedge clock);
    #1;
    chk("rst_mem_wren", 64'(bus_if.mem_wren), 64'd0);
    chk("rst_mem_wraddress", 64'(bus_if.mem_wraddress), 64'd0);
    chk("rst_mem_data", 64'(bus_if.mem_data), 64'd0);
    chk("rst_clr_busy", 64'(bus_if.clr_busy), 64'd0);
    chk("rst_clr_done", 64'(bus_if.clr_done), 64'd0);
    chk("rst_core_err", 64'(bus_if.core_err), 64'd0);
    chk("rst_core_ack", 64'(bus_if.core_ack), 64'd0);
    @(negedge clock);
    rst_n = 1'b1;

    load_req(AW'(5), 32'hDEADBEEF);
    drain();
    chk("ram_word5", 64'(ram[5]), 64'h0000_0000_DEAD_BEEF);

    load_req(AW'(N), 32'h1234_5678);
    drain();

    repeat (300) step(60, 1'b0, '0);
    drain();

    // Plain fill with a second start pulse mid-frame that must be ignored
    done_cnt = 0;
    busy_cnt = 0;
    step(0, 1'b1, 32'hA5A5A5A5);
    for (int i = 0; i < 30000 && m_clear; i++) step(0, (m_cnt == 100), 32'h0BAD_0BAD);
    chk("fill1_timeout", 64'(m_clear), 64'd0);
    drain();
    chk("fill1_done_count", 64'(done_cnt), 64'd1);
    chk("fill1_busy_cycles", 64'(busy_cnt), 64'd9601);
    chk("fill1_first_word", 64'(ram[0]), 64'h0000_0000_A5A5_A5A5);
    chk("fill1_last_word", 64'(ram[N-1]), 64'h0000_0000_A5A5_A5A5);

    // Core requesting every cycle throughout the fill
    pat2     = $urandom();
    done_cnt = 0;
    busy_cnt = 0;
    step(100, 1'b1, pat2);
    for (int i = 0; i < 60000 && m_clear; i++) step(100, 1'b0, '0);
    chk("fill2_timeout", 64'(m_clear), 64'd0);
    drain();
    chk("fill2_done_count", 64'(done_cnt), 64'd1);
    chk("fill2_busy_window", 64'((busy_cnt >= 19199) && (busy_cnt <= 19201)), 64'd1);

    // Random traffic, fill aborted by reset at counter 4000
    step(50, 1'b1, 32'h5A5A_0FF0);
    for (int i = 0; i < 20000 && m_cnt < 4000; i++) step(50, 1'b0, '0);
    @(negedge clock);
    rst_n = 1'b0;
    #1;
    chk("abort_mem_wren", 64'(bus_if.mem_wren), 64'd0);
    chk("abort_clr_busy", 64'(bus_if.clr_busy), 64'd0);
    chk("abort_clr_done", 64'(bus_if.clr_done), 64'd0);
    sbq.delete();
    model_reset();
    bus_if.core_req  = 1'b0;
    bus_if.clr_start = 1'b0;
    done_cnt = 0;
    repeat (2) @(negedge clock);
    rst_n = 1'b1;
    load_req(AW'(77), 32'hC0FFEE01);
    drain();
    chk("post_reset_word77", 64'(ram[77]), 64'h0000_0000_C0FF_EE01);
    repeat (50) step(50, 1'b0, '0);
    drain();
    chk("post_reset_no_done", 64'(done_cnt), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
